// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multicycle control unit and the ALU operation-code interface.
// Both ends of the AluOp interface import these constants so that they agree.
package mc_control_unit_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_R_WB     = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_EXEC_I   = 4'd10,
    ST_I_WB     = 4'd11,
    ST_JUMP     = 4'd12,
    ST_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOP = 6'b000000;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States whose exit into FETCH marks an instruction as retired.
  function automatic logic is_retire(state_t s);
    return s inside {ST_R_WB, ST_MEM_WB, ST_MEM_WR, ST_BRANCH, ST_I_WB, ST_JUMP};
  endfunction

endpackage

// File: rtl/mc_control_unit_alu_op_decode.sv
// R-type function field to ALU operation decoder.
// Unknown function codes report valid=0 and leave the ALU at nop.
module mc_control_unit_alu_op_decode
  import mc_control_unit_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_NOP;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_SLT:  alu_op = ALU_SLT;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_NOP:  alu_op = ALU_NOP;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control unit: sequences fetch/decode/execute/memory/writeback
// and issues datapath selects, strobes and the ALU operation code.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [3:0]       AluOp,
  output logic             Illegal,
  output logic             BusErr,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       State
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait, timeout, illegal_set, buserr_set;
  logic [3:0]        dec_op;
  logic              dec_valid;

  mc_control_unit_alu_op_decode u_alu_op_decode (
    .funct  (Funct),
    .alu_op (dec_op),
    .valid  (dec_valid)
  );

  // Last permitted waiting cycle; a MemReady arriving here still completes.
  assign timeout = !MemReady && (wait_cnt == WAIT_W'(WAIT_MAX - 1));
  assign State   = state_q;

  always_comb begin
    state_d     = state_q;
    PCEn        = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    PCSrc       = PCSRC_ALU;
    AluOp       = ALU_NOP;
    mem_wait    = 1'b0;
    illegal_set = 1'b0;
    buserr_set  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        AluOp    = ALU_ADD;
        mem_wait = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCEn    = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d    = ST_TRAP;
          buserr_set = 1'b1;
        end
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        AluOp   = ALU_ADD;
        case (Opcode)
          OP_RTYPE:     state_d = ST_EXEC_R;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_EXEC_I;
          OP_J:         state_d = ST_JUMP;
          default: begin
            state_d     = ST_TRAP;
            illegal_set = 1'b1;
          end
        endcase
      end
      ST_EXEC_R: begin
        ALUSrcA = 1'b1;
        AluOp   = dec_op;
        if (dec_valid) state_d = ST_R_WB;
        else begin
          state_d     = ST_TRAP;
          illegal_set = 1'b1;
        end
      end
      ST_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        AluOp   = ALU_ADD;
        state_d = (Opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        IorD     = 1'b1;
        MemRead  = 1'b1;
        mem_wait = 1'b1;
        if (MemReady) state_d = ST_MEM_WB;
        else if (timeout) begin
          state_d    = ST_TRAP;
          buserr_set = 1'b1;
        end
      end
      ST_MEM_WB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        mem_wait = 1'b1;
        if (MemReady) state_d = ST_FETCH;
        else if (timeout) begin
          state_d    = ST_TRAP;
          buserr_set = 1'b1;
        end
      end
      ST_BRANCH: begin
        ALUSrcA = 1'b1;
        AluOp   = ALU_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCEn    = Zero;
        state_d = ST_FETCH;
      end
      ST_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        AluOp   = ALU_ADD;
        state_d = ST_I_WB;
      end
      ST_I_WB: begin
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCEn    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt   <= '0;
      Illegal    <= 1'b0;
      BusErr     <= 1'b0;
      InstrCount <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || MemReady || !mem_wait) wait_cnt <= '0;
      else wait_cnt <= wait_cnt + 1'b1;
      if (illegal_set) Illegal <= 1'b1;
      if (buserr_set) BusErr <= 1'b1;
      if ((state_d == ST_FETCH) && is_retire(state_q)) InstrCount <= InstrCount + 1'b1;
    end
  end

endmodule
